// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline stage register with valid/ready handshake,
// a two-entry skid buffer (main + skid) and a bubble-injecting flush.
// Optional macro PIPE_STAGE_PERF_EN adds saturating stall/flush counters.
module pipe_stage_reg #(
  parameter int CTRL_W = 10,
  parameter int DATA_W = 148,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output logic [CNT_W-1:0]  perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t            state;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              up_xfer;
  logic              down_xfer;

  // Handshake flags come straight from the state register so in_ready never
  // depends combinationally on out_ready.
  assign in_ready  = (state != SKID);
  assign out_valid = (state != EMPTY);
  assign up_xfer   = in_valid & in_ready;
  assign down_xfer = out_valid & out_ready;

  // Stage FSM: main register drives the outputs, skid catches the one extra
  // entry accepted after downstream stalls; flush empties and forces a NOP.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= EMPTY;
      out_ctrl  <= '0;
      out_data  <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush) begin
      state    <= EMPTY;
      out_ctrl <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (up_xfer) begin
            out_ctrl <= in_ctrl;
            out_data <= in_data;
            state    <= FULL;
          end
        end
        FULL: begin
          if (up_xfer && down_xfer) begin
            out_ctrl <= in_ctrl;
            out_data <= in_data;
          end else if (up_xfer) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
            state     <= SKID;
          end else if (down_xfer) begin
            out_ctrl <= '0;
            state    <= EMPTY;
          end
        end
        SKID: begin
          if (down_xfer) begin
            out_ctrl <= skid_ctrl;
            out_data <= skid_data;
            state    <= FULL;
          end
        end
        default: begin
          out_ctrl <= '0;
          state    <= EMPTY;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Saturating performance counters; only reset clears them, flush does not.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (perf_stall_cnt != CNT_MAX))
        perf_stall_cnt <= perf_stall_cnt + CNT_ONE;
      if (flush && (state != EMPTY) && (perf_flush_cnt != CNT_MAX))
        perf_flush_cnt <= perf_flush_cnt + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed self-checking bench for pipe_stage_reg.
// With PIPE_STAGE_PERF_EN defined the counters are checked with CNT_W=4.
module tb_pipe_stage_reg;

  localparam int CTRL_W = 10;
  localparam int DATA_W = 148;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0]  perf_stall_cnt;
  logic [CNT_W-1:0]  perf_flush_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  pipe_stage_reg #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then advance to 1 time unit past the edge.
  task automatic apply_stimulus(input logic v, input logic [DATA_W-1:0] d,
                                input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = d[CTRL_W-1:0];
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its expected value.
  task automatic check_output(input string tag, input logic [DATA_W-1:0] obs,
                              input logic [DATA_W-1:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the full output bundle of the stage.
  task automatic check_entry(input string tag, input logic v, input logic [DATA_W-1:0] d,
                             input logic [CTRL_W-1:0] c);
    check_output({tag, "_valid"}, DATA_W'(out_valid), DATA_W'(v));
    check_output({tag, "_ctrl"},  DATA_W'(out_ctrl),  DATA_W'(c));
    check_output({tag, "_data"},  out_data, d);
  endtask

  // Directed sequence.
  initial begin
    reset = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_ctrl = '0;
    in_data = '0;
    out_ready = 1'b0;

    // Reset held 3 cycles while junk is offered.
    in_valid = 1'b1;
    in_ctrl  = 10'h3FF;
    in_data  = {DATA_W{1'b1}};
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_entry("reset", 1'b0, '0, '0);
    check_output("reset_in_ready", DATA_W'(in_ready), DATA_W'(1'b1));

    reset = 1'b1;
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    check_output("post_reset_in_ready", DATA_W'(in_ready), DATA_W'(1'b1));
    check_output("post_reset_valid", DATA_W'(out_valid), DATA_W'(1'b0));

    // Full-throughput stream 1..8.
    for (int i = 1; i <= 8; i++) begin
      apply_stimulus(1'b1, DATA_W'(i), 1'b1, 1'b0);
      check_entry($sformatf("stream%0d", i), 1'b1, DATA_W'(i), CTRL_W'(i));
    end
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    check_output("stream_drain_valid", DATA_W'(out_valid), DATA_W'(1'b0));
    check_output("stream_drain_ctrl", DATA_W'(out_ctrl), '0);

    // Backpressure: stall 3 cycles once entry 2 is on the output.
    apply_stimulus(1'b1, DATA_W'(1), 1'b1, 1'b0);
    check_entry("bp1", 1'b1, DATA_W'(1), CTRL_W'(1));
    apply_stimulus(1'b1, DATA_W'(2), 1'b1, 1'b0);
    check_entry("bp2", 1'b1, DATA_W'(2), CTRL_W'(2));
    apply_stimulus(1'b1, DATA_W'(3), 1'b0, 1'b0);
    check_entry("bp_stall1", 1'b1, DATA_W'(2), CTRL_W'(2));
    check_output("bp_in_ready_low1", DATA_W'(in_ready), DATA_W'(1'b0));
    apply_stimulus(1'b1, DATA_W'(4), 1'b0, 1'b0);
    check_entry("bp_stall2", 1'b1, DATA_W'(2), CTRL_W'(2));
    check_output("bp_in_ready_low2", DATA_W'(in_ready), DATA_W'(1'b0));
    apply_stimulus(1'b1, DATA_W'(4), 1'b0, 1'b0);
    check_entry("bp_stall3", 1'b1, DATA_W'(2), CTRL_W'(2));
    apply_stimulus(1'b1, DATA_W'(4), 1'b1, 1'b0);
    check_entry("bp3", 1'b1, DATA_W'(3), CTRL_W'(3));
    check_output("bp_in_ready_back", DATA_W'(in_ready), DATA_W'(1'b1));
    for (int i = 4; i <= 6; i++) begin
      apply_stimulus(1'b1, DATA_W'(i), 1'b1, 1'b0);
      check_entry($sformatf("bp%0d", i), 1'b1, DATA_W'(i), CTRL_W'(i));
    end
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    check_output("bp_drain_valid", DATA_W'(out_valid), DATA_W'(1'b0));

    // Flush while in SKID with a new entry offered.
    apply_stimulus(1'b1, DATA_W'('h10), 1'b0, 1'b0);
    apply_stimulus(1'b1, DATA_W'('h11), 1'b0, 1'b0);
    check_output("skid_in_ready", DATA_W'(in_ready), DATA_W'(1'b0));
    in_valid = 1'b1;
    in_ctrl  = 10'h155;
    in_data  = DATA_W'('h99);
    flush    = 1'b1;
    @(posedge clk);
    #1;
    check_entry("flush", 1'b0, DATA_W'('h10), '0);
    check_output("flush_in_ready", DATA_W'(in_ready), DATA_W'(1'b1));
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    check_output("flush_no_ghost", DATA_W'(out_valid), DATA_W'(1'b0));
    apply_stimulus(1'b1, DATA_W'('h20), 1'b1, 1'b0);
    check_entry("after_flush", 1'b1, DATA_W'('h20), CTRL_W'('h20));
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);

    // Flush and reset in the same cycle: reset wins.
    apply_stimulus(1'b1, DATA_W'('h30), 1'b0, 1'b0);
    check_entry("pre_rf", 1'b1, DATA_W'('h30), CTRL_W'('h30));
    reset = 1'b0;
    apply_stimulus(1'b1, DATA_W'('h31), 1'b0, 1'b1);
    check_entry("reset_flush", 1'b0, '0, '0);
`ifdef PIPE_STAGE_PERF_EN
    check_output("rf_flush_cnt", DATA_W'(perf_flush_cnt), '0);
    check_output("rf_stall_cnt", DATA_W'(perf_stall_cnt), '0);
`endif
    reset = 1'b1;
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);

`ifdef PIPE_STAGE_PERF_EN
    // Stall counter saturates at 15 after 20 stall cycles.
    apply_stimulus(1'b1, DATA_W'('h40), 1'b0, 1'b0);
    check_output("perf_stall_start", DATA_W'(perf_stall_cnt), '0);
    repeat (20) apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    check_output("perf_stall_sat", DATA_W'(perf_stall_cnt), DATA_W'(15));
    // Two flushes of valid entries and one while empty.
    apply_stimulus(1'b0, '0, 1'b1, 1'b1);
    check_output("perf_flush_1", DATA_W'(perf_flush_cnt), DATA_W'(1));
    apply_stimulus(1'b1, DATA_W'('h41), 1'b1, 1'b0);
    apply_stimulus(1'b0, '0, 1'b1, 1'b1);
    apply_stimulus(1'b0, '0, 1'b1, 1'b1);
    check_output("perf_flush_2", DATA_W'(perf_flush_cnt), DATA_W'(2));
    check_output("perf_stall_hold", DATA_W'(perf_stall_cnt), DATA_W'(15));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
